// File: rtl/pc_branch_unit.sv
// Program counter and branch-resolution unit.
// Works out the next PC with priority jump, then conditional branch, then
// the sequential pc + 4. It also produces a one-cycle flush pulse after each
// committed redirect, a sticky flag for the illegal beq+bne encoding, and a
// saturating count of committed redirects.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             beq,
  input  logic             bne,
  input  logic             jump,
  input  logic [15:0]      imm,
  input  logic [25:0]      target,
  input  logic             Z,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             taken,
  output logic             flush,
  output logic             illegal,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t state;

  // Turns a word offset into a sign-extended byte offset.
  function automatic logic signed [31:0] branch_offset(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

  // Adds one to the counter, but leaves it unchanged once every bit is set.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic signed [31:0] br_off_p0;
  logic [31:0]        jump_tgt_p0;
  logic [31:0]        br_tgt_p0;
  logic [31:0]        pc_next_p0;
  logic               one_hot_p0;
  logic               br_p0;
  logic               both_p0;
  logic               commit_p0;

  // Stage p0: resolve the branch and select the next PC from the current pc.
  always_comb begin
    pc_plus4    = pc + 32'd4;
    one_hot_p0  = beq ^ bne;
    both_p0     = beq & bne;
    br_p0       = one_hot_p0 & ((beq & Z) | (bne & ~Z));
    taken       = jump | br_p0;
    br_off_p0   = branch_offset(imm);
    jump_tgt_p0 = {pc_plus4[31:28], target, 2'b00};
    br_tgt_p0   = pc_plus4 + $unsigned(br_off_p0);
    commit_p0   = ~reset & ~stall;
    pc_next_p0  = pc_plus4;
    if (jump)
      pc_next_p0 = jump_tgt_p0;
    else if (br_p0)
      pc_next_p0 = br_tgt_p0;
  end

  // Program counter register. A stalled cycle leaves the current pc in place.
  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else if (!stall)
      pc <= pc_next_p0;
  end

  // Redirect FSM. flush is registered and is high exactly while in REDIRECT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      flush <= 1'b0;
    end else if (commit_p0) begin
      case (state)
        RUN: begin
          if (taken) begin
            state <= REDIRECT;
            flush <= 1'b1;
          end else begin
            state <= RUN;
            flush <= 1'b0;
          end
        end
        REDIRECT: begin
          if (taken) begin
            state <= REDIRECT;
            flush <= 1'b1;
          end else begin
            state <= RUN;
            flush <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

  // Sticky illegal-encoding flag. Only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)
      illegal <= 1'b0;
    else if (commit_p0 && both_p0)
      illegal <= 1'b1;
  end

  // Saturating count of committed redirects.
  always_ff @(posedge clk) begin
    if (reset)
      taken_cnt <= '0;
    else if (commit_p0 && taken)
      taken_cnt <= sat_inc(taken_cnt);
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit. Two instances share the stimulus: the
// default counter width, and a 2-bit counter to exercise saturation.
module tb_pc_branch_unit;

  logic        clk;
  logic        reset, stall, beq, bne, jump, Z;
  logic [15:0] imm;
  logic [25:0] target;

  logic [31:0] pc_a, pcp4_a, pc_b, pcp4_b;
  logic        taken_a, flush_a, ill_a, taken_b, flush_b, ill_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  pc_branch_unit dut_a (
    .clk(clk), .reset(reset), .stall(stall), .beq(beq), .bne(bne),
    .jump(jump), .imm(imm), .target(target), .Z(Z),
    .pc(pc_a), .pc_plus4(pcp4_a), .taken(taken_a), .flush(flush_a),
    .illegal(ill_a), .taken_cnt(cnt_a)
  );

  pc_branch_unit #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .beq(beq), .bne(bne),
    .jump(jump), .imm(imm), .target(target), .Z(Z),
    .pc(pc_b), .pc_plus4(pcp4_b), .taken(taken_b), .flush(flush_b),
    .illegal(ill_b), .taken_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        taken;
    logic        flush;
    logic        illegal;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state, stored as plain architectural values.
  logic [31:0] m_pc;
  logic        m_flush;
  logic        m_ill;
  int          m_c16;
  int          m_c2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one set of outputs per cycle, compared against the queued expectation.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("pc_a",      pc_a,    e.pc);
      chk("pcp4_a",    pcp4_a,  e.pcp4);
      chk("taken_a",   {31'd0, taken_a}, {31'd0, e.taken});
      chk("flush_a",   {31'd0, flush_a}, {31'd0, e.flush});
      chk("illegal_a", {31'd0, ill_a},   {31'd0, e.illegal});
      chk("cnt_a",     {16'd0, cnt_a},   {16'd0, e.cnt16});
      chk("pc_b",      pc_b,    e.pc);
      chk("pcp4_b",    pcp4_b,  e.pcp4);
      chk("taken_b",   {31'd0, taken_b}, {31'd0, e.taken});
      chk("flush_b",   {31'd0, flush_b}, {31'd0, e.flush});
      chk("illegal_b", {31'd0, ill_b},   {31'd0, e.illegal});
      chk("cnt_b",     {30'd0, cnt_b},   {30'd0, e.cnt2});
    end
  end

  task automatic model_reset();
    m_pc    = 32'h0000_0000;
    m_flush = 1'b0;
    m_ill   = 1'b0;
    m_c16   = 0;
    m_c2    = 0;
  endtask

  // Apply one cycle of inputs, queue the expected outputs, advance the model.
  task automatic step(input logic r, input logic s, input logic bq, input logic bn,
                      input logic j, input logic z, input logic [15:0] im,
                      input logic [25:0] tg);
    exp_t        e;
    logic [31:0] p4;
    logic        br;
    logic        tk;
    int          off;
    reset = r; stall = s; beq = bq; bne = bn; jump = j; Z = z;
    imm = im; target = tg;

    p4  = m_pc + 32'd4;
    br  = (bq != bn) && (bq ? z : !z);
    tk  = j || br;
    off = int'($signed(im)) * 4;

    e.pc      = m_pc;
    e.pcp4    = p4;
    e.taken   = tk;
    e.flush   = m_flush;
    e.illegal = m_ill;
    e.cnt16   = 16'(m_c16);
    e.cnt2    = 2'(m_c2);
    sbq.push_back(e);

    if (r) begin
      model_reset();
    end else if (!s) begin
      if (j)       m_pc = {p4[31:28], tg, 2'b00};
      else if (br) m_pc = p4 + 32'(off);
      else         m_pc = p4;
      m_flush = tk;
      if (bq && bn) m_ill = 1'b1;
      if (tk) begin
        m_c16 = (m_c16 + 1 > 65535) ? 65535 : m_c16 + 1;
        m_c2  = (m_c2 + 1 > 3) ? 3 : m_c2 + 1;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; beq = 1'b0; bne = 1'b0; jump = 1'b0;
    Z = 1'b0; imm = 16'h0; target = 26'h0;
    repeat (2) @(posedge clk);
    #2;
    model_reset();

    // Reset state, followed by a sequential run to pc = 0x10.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    repeat (4) idle();
    // Taken beq backwards at 0x10 to 0x04, then check the flush pulse.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFC, 26'h0);
    repeat (3) idle();
    // At 0x10: bne with Z=1 is not taken; then a jump wins over beq.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 26'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0020, 26'h000_0040);
    idle();
    // A taken branch stalled for two cycles, then released.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0008, 26'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0008, 26'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0008, 26'h0);
    idle();
    // The illegal beq+bne encoding is treated as no branch; the flag is sticky.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 26'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 26'h000_0200);
    repeat (2) idle();
    // Reset in the cycle after a taken branch cancels the pending flush.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 26'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    // Branch from 0 to 0xFFFFFFFC, then wrap to 0.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFE, 26'h0);
    repeat (2) idle();
    // Five taken jumps saturate the 2-bit counter.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'(i * 8));
    idle();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic r, s, bq, bn, j, z;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0);
      bq = ($urandom_range(0, 2) == 0);
      bn = ($urandom_range(0, 2) == 0);
      j  = ($urandom_range(0, 5) == 0);
      z  = 1'($urandom_range(0, 1));
      step(r, s, bq, bn, j, z, 16'($urandom), 26'($urandom));
    end

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit reached");
  end

endmodule
